// File: rtl/serial_ctrl_pkg.sv
// Shared types and defaults for the serial shift register controller.
package serial_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; on contention the requester that did not win last time is granted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
        last_grant_d = last_grant_q;
        if (advance) begin
            last_grant_d = grant[1];
        end
    end

    // Starts at 1 so that requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/serial_shift_ctrl.sv
// Arbitrates two swap requesters, streams the granted word into an external serial
// shift register and collects the bits it pushes out as the response word.
module serial_shift_ctrl
    import serial_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_dir,
    input  logic [2*WIDTH-1:0] req_data,
    output logic [1:0]         req_ready,
    output logic               sr_enable,
    output logic               sr_dir,
    output logic               sr_in_bit,
    input  logic               sr_out_bit,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_data
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   tx_q, tx_d;
    logic               dir_q, dir_d;
    logic               id_q, id_d;
    logic               sr_enable_q, sr_enable_d;
    logic               sr_dir_q, sr_dir_d;
    logic               sr_in_bit_q, sr_in_bit_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic [1:0]         grant;
    logic               advance;
    logic               g_idx;
    logic [WIDTH-1:0]   sel_data;

    // dir=0 fills from the LSB end (MSB arrives first), dir=1 fills from the MSB end.
    function automatic logic [WIDTH-1:0] capture(input logic [WIDTH-1:0] cur,
                                                 input logic dir,
                                                 input logic b);
        return dir ? {b, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], b};
    endfunction

    assign advance  = (state_q == IDLE) && (|req_valid);
    assign g_idx    = grant[1];
    assign sel_data = g_idx ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        dir_d       = dir_q;
        id_d        = id_q;
        sr_enable_d = 1'b0;
        sr_dir_d    = sr_dir_q;
        sr_in_bit_d = sr_in_bit_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        req_ready   = 2'b00;

        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (advance) begin
                    state_d     = SHIFT;
                    cnt_d       = '0;
                    tx_d        = sel_data;
                    dir_d       = req_dir[g_idx];
                    id_d        = g_idx;
                    sr_enable_d = 1'b1;
                    sr_dir_d    = req_dir[g_idx];
                    sr_in_bit_d = req_dir[g_idx] ? sel_data[0] : sel_data[WIDTH-1];
                end
            end
            SHIFT: begin
                // The first strobe's output bit is not visible until the second cycle.
                if (cnt_q != '0) begin
                    rsp_data_d = capture(rsp_data_q, dir_q, sr_out_bit);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DRAIN;
                end else begin
                    sr_enable_d = 1'b1;
                    tx_d        = dir_q ? (tx_q >> 1) : (tx_q << 1);
                    sr_in_bit_d = dir_q ? tx_q[1] : tx_q[WIDTH-2];
                end
            end
            DRAIN: begin
                rsp_data_d = capture(rsp_data_q, dir_q, sr_out_bit);
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_q        <= '0;
            dir_q       <= 1'b0;
            id_q        <= 1'b0;
            sr_enable_q <= 1'b0;
            sr_dir_q    <= 1'b0;
            sr_in_bit_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            dir_q       <= dir_d;
            id_q        <= id_d;
            sr_enable_q <= sr_enable_d;
            sr_dir_q    <= sr_dir_d;
            sr_in_bit_q <= sr_in_bit_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign sr_enable = sr_enable_q;
    assign sr_dir    = sr_dir_q;
    assign sr_in_bit = sr_in_bit_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Bench for serial_shift_ctrl: models the external shift register and predicts grants,
// serial bit streams and responses from the request words.
module tb_serial_shift_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_dir;
    logic [2*W-1:0] req_data;
    logic [1:0]     req_ready;
    logic           sr_enable;
    logic           sr_dir;
    logic           sr_in_bit;
    logic           sr_out_bit = 1'b0;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_data;

    logic [W-1:0]   reg_m = '0;
    int             n_checks = 0;
    int             n_pass = 0;
    int             last_g = 1;

    serial_shift_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_dir    (req_dir),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .sr_enable  (sr_enable),
        .sr_dir     (sr_dir),
        .sr_in_bit  (sr_in_bit),
        .sr_out_bit (sr_out_bit),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    // External shift register: moves only on a strobe, serial output is registered.
    always @(posedge clk) begin
        if (sr_enable) begin
            if (!sr_dir) begin
                sr_out_bit <= reg_m[W-1];
                reg_m      <= {reg_m[W-2:0], sr_in_bit};
            end else begin
                sr_out_bit <= reg_m[0];
                reg_m      <= {sr_in_bit, reg_m[W-1:1]};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_sr_enable"}, 32'(sr_enable), 32'd0);
        chk({tag, "_sr_dir"},    32'(sr_dir),    32'd0);
        chk({tag, "_sr_in_bit"}, 32'(sr_in_bit), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        step();
        step();
        #1;
        reset_n = 1'b1;
        last_g  = 1;
    endtask

    // One full transaction from the IDLE cycle through the response handshake.
    task automatic txn(input logic [1:0] vld, input logic [1:0] dir,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input int stall, input bit drop);
        int           g;
        int           waited;
        logic [W-1:0] gd;
        logic [W-1:0] exp_rsp;
        logic         gdir;
        logic         exp_bit;
        req_valid = vld;
        req_dir   = dir;
        req_data  = {d1, d0};
        #1;
        waited = 0;
        while (req_ready == 2'b00 && waited < 40) begin
            step();
            waited++;
        end
        if (req_ready == 2'b00) begin
            chk("grant_timeout", 32'd0, 32'd1);
            return;
        end
        g       = (vld == 2'b11) ? (1 - last_g) : (vld[1] ? 1 : 0);
        last_g  = g;
        chk("grant", 32'(req_ready), 32'(2'b01 << g));
        gd      = (g == 1) ? d1 : d0;
        gdir    = dir[g];
        exp_rsp = reg_m;
        step();
        if (drop) req_valid[g] = 1'b0;
        for (int k = 1; k <= W; k++) begin
            exp_bit = gdir ? gd[k-1] : gd[W-k];
            chk("shift_enable", 32'(sr_enable), 32'd1);
            chk("shift_dir",    32'(sr_dir),    32'(gdir));
            chk("shift_bit",    32'(sr_in_bit), 32'(exp_bit));
            chk("shift_ready",  32'(req_ready), 32'd0);
            step();
        end
        chk("drain_enable", 32'(sr_enable), 32'd0);
        chk("drain_valid",  32'(rsp_valid), 32'd0);
        step();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id",    32'(rsp_id),    32'(g));
        chk("rsp_data",  32'(rsp_data),  32'(exp_rsp));
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_valid",  32'(rsp_valid), 32'd1);
            chk("stall_data",   32'(rsp_data),  32'(exp_rsp));
            chk("stall_enable", 32'(sr_enable), 32'd0);
            chk("stall_ready",  32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_data",  32'(rsp_data),  32'(exp_rsp));
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_dir   = 2'b00;
        req_data  = '0;
        rsp_ready = 1'b0;
        do_reset();

        // Requester 0, MSB first; register starts empty.
        txn(2'b01, 2'b00, 8'hA5, 8'h00, 0, 1'b1);
        chk("first_rsp_const", 32'(rsp_data), 32'h00);
        chk("first_id_const",  32'(rsp_id),   32'd0);

        // Requester 1, LSB first; gets back the first word.
        txn(2'b10, 2'b10, 8'h00, 8'h3C, 0, 1'b1);
        chk("second_rsp_const", 32'(rsp_data), 32'hA5);
        chk("second_id_const",  32'(rsp_id),   32'd1);

        // Contention from reset: alternating grants.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            txn(2'b11, 2'(i), 8'(8'h11 * (i + 1)), 8'(8'h90 + i), 0, 1'b0);
            chk("contention_order", 32'(rsp_id), 32'(i % 2));
        end

        // Backpressure with both requesters still asking.
        txn(2'b11, 2'b01, 8'h5A, 8'hC3, 20, 1'b0);

        // Reset in the middle of the shift phase.
        req_valid = 2'b11;
        req_dir   = 2'b00;
        req_data  = {8'hF0, 8'h0F};
        #1;
        chk("abort_grant", 32'(req_ready), 32'(2'b01 << (1 - last_g)));
        for (int i = 0; i < 4; i++) step();
        #1;
        req_valid = 2'b00;
        reset_n   = 1'b0;
        #1;
        check_reset_outputs("abort");
        step();
        #1;
        reset_n = 1'b1;
        last_g  = 1;
        txn(2'b11, 2'b00, 8'h66, 8'h99, 0, 1'b1);
        chk("after_abort_id", 32'(rsp_id), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            txn(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
